// File: rtl/dac_top.sv
// dac_top: sawtooth/triangle sigma-delta DAC pair from a shared phase accumulator, plus clock divider.
// Define DAC_PLL_EN to source fast_clk from an rPLL instead of forwarding clk27 directly.
module dac_top #(
  parameter int WIDTH      = 8,
  parameter int PHASE_STEP = 64,
  parameter int SLOW_DIV   = 4
) (
  input  logic clk27,
  input  logic n_rst,
  output logic dac_1,
  output logic dac_2,
  output logic fast_clk,
  output logic slow_clk
);
  logic [15:0]         r_phase;
  logic [WIDTH:0]      r_acc1, r_acc2;
  logic [SLOW_DIV-1:0] r_cnt;
  logic                r_slow;
  logic [WIDTH-1:0]    w_s1, w_s2;

  assign w_s1 = r_phase[15 -: WIDTH];
  assign w_s2 = r_phase[15] ? ~r_phase[14 -: WIDTH] : r_phase[14 -: WIDTH];

  always_ff @(posedge clk27) begin
    if (n_rst) begin
      r_phase <= '0;
      r_acc1  <= '0;
      r_acc2  <= '0;
      r_cnt   <= '0;
      r_slow  <= 1'b0;
    end else begin
      r_phase <= r_phase + 16'(PHASE_STEP);
      r_acc1  <= {1'b0, r_acc1[WIDTH-1:0]} + {1'b0, w_s1};
      r_acc2  <= {1'b0, r_acc2[WIDTH-1:0]} + {1'b0, w_s2};
      r_cnt   <= r_cnt + SLOW_DIV'(1);
      r_slow  <= r_slow ^ (&r_cnt);
    end
  end

  assign dac_1    = r_acc1[WIDTH];
  assign dac_2    = r_acc2[WIDTH];
  assign slow_clk = r_slow;

`ifdef DAC_PLL_EN
  rPLL u_pll (
    .CLKOUT   (fast_clk),
    .LOCK     (),
    .CLKOUTP  (),
    .CLKOUTD  (),
    .CLKOUTD3 (),
    .RESET    (1'b0),
    .RESET_P  (1'b0),
    .CLKIN    (clk27),
    .CLKFB    (1'b0),
    .FBDSEL   (6'd0),
    .IDSEL    (6'd0),
    .ODSEL    (6'd0),
    .PSDA     (4'd0),
    .DUTYDA   (4'd0),
    .FDLY     (4'd0)
  );
`else
  assign fast_clk = clk27;
`endif
endmodule

// File: tb/tb_dac_top.sv
// tb_dac_top: directed checks of reset, divider, sigma-delta densities, mid-run reset and clock forwarding.
module tb_dac_top;
  logic clk27 = 1'b0;
  logic n_rst = 1'b1;
  logic dac_1, dac_2, fast_clk, slow_clk;
  int   n_pass = 0;
  int   n_total = 0;

  dac_top dut (
    .clk27    (clk27),
    .n_rst    (n_rst),
    .dac_1    (dac_1),
    .dac_2    (dac_2),
    .fast_clk (fast_clk),
    .slow_clk (slow_clk)
  );

  always #5 clk27 = ~clk27;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask

  always @(clk27) begin
    #1;
    chk("fwd", int'(fast_clk), int'(clk27));
  end

  task automatic window(input int n, input int exp1, input int exp2);
    int c1 = 0;
    int c2 = 0;
    for (int t = 1; t <= n; t++) begin
      @(posedge clk27);
      #1;
      c1 += int'(dac_1);
      c2 += int'(dac_2);
      if (t <= 4) chk("saw_start", int'(dac_1), 0);
      chk("slow", int'(slow_clk), (t / 16) % 2);
    end
    chk("saw_ones", c1, exp1);
    chk("tri_ones", c2, exp2);
  endtask

  initial begin
    n_rst = 1'b1;
    repeat (25) begin
      @(posedge clk27);
      #1;
      chk("rst_dac1", int'(dac_1), 0);
      chk("rst_dac2", int'(dac_2), 0);
      chk("rst_slow", int'(slow_clk), 0);
    end
    n_rst = 1'b0;
    window(1024, 510, 510);
    n_rst = 1'b1;
    @(posedge clk27);
    #1;
    n_rst = 1'b0;
    repeat (700) @(posedge clk27);
    #1;
    n_rst = 1'b1;
    @(posedge clk27);
    #1;
    chk("mid_dac1", int'(dac_1), 0);
    chk("mid_dac2", int'(dac_2), 0);
    chk("mid_slow", int'(slow_clk), 0);
    n_rst = 1'b0;
    window(256, 31, 63);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dac_top.md
DAC_TOP -- requirements
Module: dac_top

Interface
REQ-001 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 8: DAC sample width in bits.
REQ-003 Parameter PHASE_STEP, default 64: phase-accumulator increment per clock.
REQ-004 Parameter SLOW_DIV, default 4: slow_clk divider exponent; slow_clk toggles every 2^SLOW_DIV clocks.
REQ-005 clk27  input  1  system clock; all logic is clocked on its rising edge.
REQ-006 n_rst  input  1  synchronous, active-high reset (1 = reset asserted), sampled on the clk27 rising edge.
REQ-007 dac_1  output  1  sigma-delta bitstream of the sawtooth waveform.
REQ-008 dac_2  output  1  sigma-delta bitstream of the triangle waveform.
REQ-009 fast_clk  output  1  forwarded high-speed clock.
REQ-010 slow_clk  output  1  divided clock, 50% duty.

Function
REQ-011 Phase: 16-bit register; phase <= phase + PHASE_STEP each clock, modulo 2^16; wraps silently.
REQ-012 Sawtooth sample s1 = phase[15:8] (combinational from the phase register).
REQ-013 Triangle sample s2 = phase[14:7] when phase[15]=0, else bitwise NOT of phase[14:7].
REQ-014 Modulators: each channel has a 9-bit accumulator; acc <= {0, acc[7:0]} + {0, sample} each clock.
REQ-015 dac_1 = acc1[8] and dac_2 = acc2[8], read directly from the registers with no further logic.
REQ-016 Ones density of each output equals sample/256; sample 0 gives constant 0; sample 255 gives 255 ones per 256 clocks.
REQ-017 Latency: a phase update affects the dac output one clock later.
REQ-018 Divider: SLOW_DIV-bit counter increments each clock; slow_clk toggles on the clock where the counter wraps from all-ones to 0.
REQ-019 Divider period: slow_clk period is 2^(SLOW_DIV+1) clocks, i.e. 32 at the default.
REQ-020 Channel independence: the two channels share only the phase register.

Reset
REQ-021 While n_rst=1 at a clock edge, the following clear to 0: phase, both accumulators, divider counter, dac_1, dac_2, slow_clk.
REQ-022 After reset release, the first phase increment occurs on the first edge with n_rst=0.
REQ-023 Reset asserted mid-operation clears all state on the next edge; no partial state is retained.
REQ-024 fast_clk is not affected by reset.

Configuration
REQ-025 Macro DAC_PLL_EN defined: fast_clk is CLKOUT of an instantiated rPLL primitive.
REQ-026 rPLL connections under DAC_PLL_EN: CLKIN=clk27, RESET=0, RESET_P=0, CLKFB=0, all DSEL/PSDA/DUTYDA/FDLY inputs tied 0.
REQ-027 Macro DAC_PLL_EN undefined: fast_clk = clk27 by direct assignment, and no PLL is instantiated.
REQ-028 All other logic is identical with or without DAC_PLL_EN.

Verification
REQ-029 Reset: hold n_rst=1 for 25 clocks -> dac_1=0, dac_2=0, slow_clk=0 throughout.
REQ-030 Divider: release reset -> slow_clk rises after 16 clocks, then toggles every 16 clocks (period 32).
REQ-031 Sawtooth: count dac_1 ones over the 1024 clocks following release -> 510 ±1; dac_1=0 for the first 4 clocks (s1=0).
REQ-032 Triangle: count dac_2 ones over the same 1024 clocks -> 510 ±1.
REQ-033 Mid-run reset: assert n_rst for 1 clock at clock 700 -> state equals the post-reset state, and the phase sequence restarts at 0.
REQ-034 Clock forward: with DAC_PLL_EN undefined, or with the pass-through PLL model -> fast_clk is identical to clk27 at every time step.
